// File: rtl/lzw_dict_ctrl.sv
// lzw_dict_ctrl
//   Sequences one LZW dictionary lookup/insert at a time across the hashed
//   main dictionary RAM and the 16-entry conflict table (CT). A request key
//   {prefix_code, char} is hashed, the RAM slot is read and the CT probed in
//   parallel. A hit returns the stored code. A miss allocates the next free
//   code into the RAM slot, or into the CT if the slot is taken.
//
//   Transaction timing: accept on edge T (IDLE), RD, CMP, RESP. rsp_valid is
//   high for the single RESP cycle and the next accept can happen on the edge
//   that leaves RESP.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   req_valid/req_ready/     request handshake (ready only in IDLE) and key
//   req_key
//   rsp_valid/rsp_status/    one-cycle response: 00 HIT, 01 INSERTED,
//   rsp_code                 10 DICT_FULL, 11 OVERFLOW; code is 0 for 10/11
//   dict_full                registered next_code > MAX_CODE
//   ram_rd_en/ram_we/        dictionary RAM port, words are {valid,key,code},
//   ram_addr/ram_wdata/      read data valid the cycle after ram_rd_en
//   ram_rdata
//   ct_cs/ct_we/ct_key/      conflict table port; ct_match/ct_map_out are
//   ct_hash/ct_map/          combinational on ct_key, ct_full when all 16
//   ct_match/ct_map_out/     entries are used
//   ct_full
module lzw_dict_ctrl #(
  parameter int KEY_WIDTH  = 20,
  parameter int HASH_WIDTH = 12,
  parameter int CODE_WIDTH = 12,
  parameter int FIRST_CODE = 256,
  parameter int MAX_CODE   = 4095
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [KEY_WIDTH-1:0]                req_key,
  output logic                                rsp_valid,
  output logic [1:0]                          rsp_status,
  output logic [CODE_WIDTH-1:0]               rsp_code,
  output logic                                dict_full,
  output logic                                ram_rd_en,
  output logic                                ram_we,
  output logic [HASH_WIDTH-1:0]               ram_addr,
  output logic [KEY_WIDTH+CODE_WIDTH:0]       ram_wdata,
  input  logic [KEY_WIDTH+CODE_WIDTH:0]       ram_rdata,
  output logic                                ct_cs,
  output logic                                ct_we,
  output logic [KEY_WIDTH-1:0]                ct_key,
  output logic [HASH_WIDTH-1:0]               ct_hash,
  output logic [CODE_WIDTH-1:0]               ct_map,
  input  logic                                ct_match,
  input  logic [CODE_WIDTH-1:0]               ct_map_out,
  input  logic                                ct_full
);

  localparam int RAM_W = 1 + KEY_WIDTH + CODE_WIDTH;
  // One extra bit so next_code can sit at MAX_CODE+1 once the dictionary is full.
  localparam int NC_W  = CODE_WIDTH + 1;
  localparam logic [NC_W-1:0] NC_FIRST = NC_W'(FIRST_CODE);
  localparam logic [NC_W-1:0] NC_MAX   = NC_W'(MAX_CODE);
  localparam logic [NC_W-1:0] NC_SAT   = NC_W'(MAX_CODE + 1);

  typedef enum logic [1:0] {IDLE, RD, CMP, RESP} state_t;
  typedef enum logic [1:0] {
    ST_HIT       = 2'b00,
    ST_INSERTED  = 2'b01,
    ST_DICT_FULL = 2'b10,
    ST_OVERFLOW  = 2'b11
  } status_t;
  typedef enum logic [1:0] {WR_NONE, WR_RAM, WR_CT} wr_t;

  state_t                  state, state_nxt;
  logic [KEY_WIDTH-1:0]    key_q;
  logic [HASH_WIDTH-1:0]   hash_q;
  logic [NC_W-1:0]         next_code, next_code_nxt;
  status_t                 status_q, out_status;
  logic [CODE_WIDTH-1:0]   code_q, out_code;
  wr_t                     wr_q, out_wr;
  logic                    dict_full_q;

  logic                    ram_valid;
  logic [KEY_WIDTH-1:0]    ram_key;
  logic [CODE_WIDTH-1:0]   ram_code;

  // Upper key bits are folded onto the low bits shifted left by 4.
  function automatic logic [HASH_WIDTH-1:0] key_hash(input logic [KEY_WIDTH-1:0] k);
    logic [HASH_WIDTH-1:0] hi;
    hi = HASH_WIDTH'(k >> HASH_WIDTH);
    return k[HASH_WIDTH-1:0] ^ (hi << 4);
  endfunction

  assign ram_valid = ram_rdata[RAM_W-1];
  assign ram_key   = ram_rdata[RAM_W-2 -: KEY_WIDTH];
  assign ram_code  = ram_rdata[CODE_WIDTH-1:0];

  // Address/data outputs come straight from registers that only change at
  // accept (key/hash) or at the end of CMP (code), so they hold their last
  // value whenever the block is idle.
  assign ram_addr   = hash_q;
  assign ram_wdata  = {1'b1, key_q, code_q};
  assign ct_key     = key_q;
  assign ct_hash    = hash_q;
  assign ct_map     = code_q;
  assign rsp_status = status_q;
  assign rsp_code   = code_q;
  assign dict_full  = dict_full_q;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_rd_en = 1'b0;
    ram_we    = 1'b0;
    ct_cs     = 1'b0;
    ct_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = RD;
      end
      RD: begin
        ram_rd_en = 1'b1;
        state_nxt = CMP;
      end
      CMP: begin
        ct_cs     = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (wr_q == WR_RAM) ram_we = 1'b1;
        if (wr_q == WR_CT) begin
          ct_cs = 1'b1;
          ct_we = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outcome of a lookup, evaluated on the RAM read data and CT probe that are
  // valid during CMP. Key 0 never goes to the CT since the CT cannot match it.
  always_comb begin
    out_status = ST_OVERFLOW;
    out_code   = '0;
    out_wr     = WR_NONE;
    if (ram_valid && ram_key == key_q) begin
      out_status = ST_HIT;
      out_code   = ram_code;
    end else if (ct_match) begin
      out_status = ST_HIT;
      out_code   = ct_map_out;
    end else if (next_code > NC_MAX) begin
      out_status = ST_DICT_FULL;
    end else if (!ram_valid) begin
      out_status = ST_INSERTED;
      out_code   = next_code[CODE_WIDTH-1:0];
      out_wr     = WR_RAM;
    end else if (key_q != '0 && !ct_full) begin
      out_status = ST_INSERTED;
      out_code   = next_code[CODE_WIDTH-1:0];
      out_wr     = WR_CT;
    end
  end

  always_comb begin
    next_code_nxt = next_code;
    if (state == RESP && status_q == ST_INSERTED && next_code < NC_SAT)
      next_code_nxt = next_code + NC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_q       <= '0;
      hash_q      <= '0;
      next_code   <= NC_FIRST;
      status_q    <= ST_HIT;
      code_q      <= '0;
      wr_q        <= WR_NONE;
      dict_full_q <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        key_q  <= req_key;
        hash_q <= key_hash(req_key);
      end
      if (state == CMP) begin
        status_q <= out_status;
        code_q   <= out_code;
        wr_q     <= out_wr;
      end
      next_code   <= next_code_nxt;
      dict_full_q <= (next_code_nxt > NC_MAX);
    end
  end

endmodule

// File: tb/tb_lzw_dict_ctrl.sv
// tb_lzw_dict_ctrl
//   Bench for lzw_dict_ctrl. Provides a synchronous-read dictionary RAM and a
//   16-entry conflict table, predicts every response from a key->code map plus
//   per-slot occupancy and a CT fill count, and checks the DUT on every
//   negative clock edge. Directed cases pin the predictions to hand values.
module tb_lzw_dict_ctrl;
  localparam int KW = 20;
  localparam int HW = 12;
  localparam int CW = 12;
  localparam int RW = 1 + KW + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [KW-1:0] req_key = '0;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic [CW-1:0] rsp_code;
  logic          dict_full;
  logic          ram_rd_en, ram_we;
  logic [HW-1:0] ram_addr;
  logic [RW-1:0] ram_wdata, ram_rdata;
  logic          ct_cs, ct_we;
  logic [KW-1:0] ct_key;
  logic [HW-1:0] ct_hash;
  logic [CW-1:0] ct_map;
  logic          ct_match;
  logic [CW-1:0] ct_map_out;
  logic          ct_full;

  always #5 clk = ~clk;

  lzw_dict_ctrl #(
    .KEY_WIDTH (KW),
    .HASH_WIDTH(HW),
    .CODE_WIDTH(CW),
    .FIRST_CODE(256),
    .MAX_CODE  (4095)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_code(rsp_code),
    .dict_full(dict_full),
    .ram_rd_en(ram_rd_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ct_cs(ct_cs), .ct_we(ct_we), .ct_key(ct_key), .ct_hash(ct_hash),
    .ct_map(ct_map), .ct_match(ct_match), .ct_map_out(ct_map_out),
    .ct_full(ct_full)
  );

  // Dictionary RAM: read data appears the cycle after ram_rd_en; on other
  // cycles the read bus carries random junk marked valid.
  logic [RW-1:0] mem [4096];
  logic          ram_clr = 1'b0;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
    else           ram_rdata <= {1'b1, 32'($urandom())};
  end

  // Conflict table: cleared by rst, never matches key 0.
  logic [KW-1:0] ctk [16];
  logic [CW-1:0] ctm [16];
  logic [4:0]    ct_n;
  always @(posedge clk) begin
    if (!rst) ct_n <= '0;
    else if (ct_cs && ct_we && ct_n < 5'd16) begin
      ctk[ct_n[3:0]] <= ct_key;
      ctm[ct_n[3:0]] <= ct_map;
      ct_n <= ct_n + 5'd1;
    end
  end
  always_comb begin
    ct_match   = 1'b0;
    ct_map_out = 12'hABC;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < ct_n && ct_key != '0 && ctk[i] == ct_key) begin
        ct_match = 1'b1;
        if (ct_cs && !ct_we) ct_map_out = ctm[i];
      end
    end
  end
  assign ct_full = (ct_n == 5'd16);

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [1:0]    st;
    logic [CW-1:0] code;
    int            wr;     // 0 none, 1 RAM, 2 CT
    logic [KW-1:0] key;
    logic [HW-1:0] hash;
  } exp_t;

  int   dict [int];
  bit   slot_used [4096];
  int   mct, mnext;
  int   keys_q [$];
  exp_t expq [$];
  int   drop_due = -1;
  int   cyc = 0;
  bit   chk_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]    obs_st    = 2'bxx;
  logic [CW-1:0] obs_code  = 'x;
  logic [HW-1:0] obs_addr  = 'x;
  logic          obs_vbit  = 1'bx;
  logic [CW-1:0] obs_ctmap = 'x;
  logic [HW-1:0] obs_cthash = 'x;

  function automatic logic [HW-1:0] mhash(input logic [KW-1:0] k);
    return k[11:0] ^ {k[19:12], 4'h0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    dict.delete();
    foreach (slot_used[i]) slot_used[i] = 1'b0;
    keys_q.delete();
    mct   = 0;
    mnext = 256;
  endtask

  task automatic predict(input logic [KW-1:0] k, output exp_t e);
    int h;
    e.key  = k;
    e.hash = mhash(k);
    e.wr   = 0;
    e.code = '0;
    e.due  = 0;
    h = int'(e.hash);
    if (dict.exists(int'(k))) begin
      e.st = 2'b00; e.code = CW'(dict[int'(k)]);
    end else if (mnext > 4095) begin
      e.st = 2'b10;
    end else if (!slot_used[h]) begin
      e.st = 2'b01; e.code = CW'(mnext); e.wr = 1;
      slot_used[h] = 1'b1; dict[int'(k)] = mnext; keys_q.push_back(int'(k)); mnext++;
    end else if (k != '0 && mct < 16) begin
      e.st = 2'b01; e.code = CW'(mnext); e.wr = 2;
      mct++; dict[int'(k)] = mnext; keys_q.push_back(int'(k)); mnext++;
    end else begin
      e.st = 2'b11;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the transaction in flight.
  always @(negedge clk) begin : compare
    bit   has, ev, erd, ecmp, drop, busy;
    int   wr;
    exp_t e;
    if (chk_on) begin
      has = expq.size() > 0;
      ev = 0; erd = 0; ecmp = 0; drop = 0; busy = 0; wr = 0;
      if (has) begin
        e    = expq[0];
        erd  = (cyc == e.due - 2);
        ecmp = (cyc == e.due - 1);
        drop = (e.due == drop_due);
        ev   = (cyc == e.due) && !drop;
        if (ev) wr = e.wr;
        busy = (cyc >= e.due - 2) && (cyc <= e.due) && !(drop && cyc == e.due);
      end
      chk("strobes{ready,rsp_valid,rd_en,ram_we,ct_cs,ct_we}",
          64'({req_ready, rsp_valid, ram_rd_en, ram_we, ct_cs, ct_we}),
          64'({!busy, ev, erd, wr == 1, ecmp || wr == 2, wr == 2}));
      if (erd)  chk("ram_addr_read", 64'(ram_addr), 64'(e.hash));
      if (ecmp) chk("ct_key_probe", 64'(ct_key), 64'(e.key));
      if (ev) begin
        chk("rsp_status", 64'(rsp_status), 64'(e.st));
        chk("rsp_code", 64'(rsp_code), 64'(e.code));
        obs_st   = rsp_status;
        obs_code = rsp_code;
        if (wr == 1) begin
          chk("ram_addr_write", 64'(ram_addr), 64'(e.hash));
          chk("ram_wdata", 64'(ram_wdata), 64'({1'b1, e.key, e.code}));
          obs_addr = ram_addr;
          obs_vbit = ram_wdata[RW-1];
        end
        if (wr == 2) begin
          chk("ct_key_write", 64'(ct_key), 64'(e.key));
          chk("ct_hash_write", 64'(ct_hash), 64'(e.hash));
          chk("ct_map_write", 64'(ct_map), 64'(e.code));
          obs_ctmap  = ct_map;
          obs_cthash = ct_hash;
        end
      end
      if (has && cyc >= e.due) void'(expq.pop_front());
    end
  end

  // Issue one request; with drop set, rst is pulled low during CMP.
  task automatic do_req(input logic [KW-1:0] k, input int gap, input bit drop);
    exp_t e;
    chk("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_key   = k;
    @(posedge clk); #1;
    predict(k, e);
    e.due = cyc + 2;
    expq.push_back(e);
    // junk requests while busy must be ignored
    req_valid = 1'($urandom_range(0, 1));
    req_key   = KW'($urandom());
    if (drop) begin
      @(posedge clk); #1;
      rst = 1'b0;
      drop_due = e.due;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end else begin
      repeat (3) @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("dict_full", 64'(dict_full), 64'(mnext > 4095));
    end
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0]    u;
    logic [KW-1:0] k;
    rst = 1'b0;
    ram_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ram_clr = 1'b0;
    model_reset();
    chk_on = 1'b1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_status", 64'(rsp_status), 64'(0));
    chk("reset_rsp_code", 64'(rsp_code), 64'(0));
    chk("reset_dict_full", 64'(dict_full), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // first insert into empty RAM, then hit
    do_req(20'h00141, 1, 0);
    chk("lit_ins256_status", 64'(obs_st), 64'(2'b01));
    chk("lit_ins256_code", 64'(obs_code), 64'(256));
    chk("lit_ins256_addr", 64'(obs_addr), 64'(12'h141));
    chk("lit_ins256_valid", 64'(obs_vbit), 64'(1));
    do_req(20'h00141, 0, 0);
    chk("lit_hit256_status", 64'(obs_st), 64'(2'b00));
    chk("lit_hit256_code", 64'(obs_code), 64'(256));

    // same hash 0x141 -> goes to CT, then hit via ct_match
    do_req(20'h01151, 0, 0);
    chk("lit_ct257_status", 64'(obs_st), 64'(2'b01));
    chk("lit_ct257_map", 64'(obs_ctmap), 64'(257));
    chk("lit_ct257_hash", 64'(obs_cthash), 64'(12'h141));
    do_req(20'h01151, 2, 0);
    chk("lit_cthit257_status", 64'(obs_st), 64'(2'b00));
    chk("lit_cthit257_code", 64'(obs_code), 64'(257));

    // occupy slot 0, then colliding key 0 must overflow with free CT
    do_req(20'h01010, 0, 0);
    chk("lit_slot0_code", 64'(obs_code), 64'(258));
    chk("lit_slot0_addr", 64'(obs_addr), 64'(0));
    do_req(20'h00000, 0, 0);
    chk("lit_key0_status", 64'(obs_st), 64'(2'b11));
    chk("lit_key0_code", 64'(obs_code), 64'(0));

    // fill the CT with 15 more keys hashing to 0x141
    for (int i = 2; i <= 16; i++) begin
      u = 8'(i);
      k = {u, 12'h141 ^ {u, 4'h0}};
      do_req(k, 0, 0);
      chk("lit_ctfill_code", 64'(obs_code), 64'(257 + i));
    end
    u = 8'd17;
    k = {u, 12'h141 ^ {u, 4'h0}};
    do_req(k, 1, 0);
    chk("lit_ctfull_status", 64'(obs_st), 64'(2'b11));
    chk("lit_ctfull_code", 64'(obs_code), 64'(0));
    do_req(20'h00777, 0, 0);
    chk("lit_after_ovf_code", 64'(obs_code), 64'(274));

    // random mix of repeats and fresh keys
    for (int n = 0; n < 300; n++) begin
      if (keys_q.size() > 0 && $urandom_range(0, 1) == 1)
        k = KW'(keys_q[$urandom_range(0, keys_q.size() - 1)]);
      else if ($urandom_range(0, 19) == 0)
        k = '0;
      else
        k = KW'($urandom());
      do_req(k, int'($urandom_range(0, 2)), 0);
    end

    // reset during CMP drops the request and its write
    do_req(20'h12345, 0, 1);
    ram_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ram_clr = 1'b0;
    model_reset();
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_mid_rsp_status", 64'(rsp_status), 64'(0));
    chk("rst_mid_rsp_code", 64'(rsp_code), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(req_ready), 64'(1));
    do_req(20'h12345, 0, 0);
    chk("lit_after_rst_code", 64'(obs_code), 64'(256));

    // allocate every remaining code
    for (int h = 0; h < 4096 && mnext <= 4095; h++) begin
      if (!slot_used[h]) do_req(KW'(h), 0, 0);
    end
    chk("lit_last_code", 64'(obs_code), 64'(4095));
    chk("lit_dict_full_set", 64'(dict_full), 64'(1));
    do_req(20'hFFFFF, 0, 0);
    chk("lit_full_status", 64'(obs_st), 64'(2'b10));
    chk("lit_full_code", 64'(obs_code), 64'(0));
    do_req(20'h12345, 0, 0);
    chk("lit_full_hit_status", 64'(obs_st), 64'(2'b00));
    chk("lit_full_hit_code", 64'(obs_code), 64'(256));

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
